// File: rtl/sram_to_fifo_if.sv
// rtl/sram_to_fifo_if.sv - control, SRAM read and FIFO push signal bundle for sram_to_fifo
//
// Purpose: groups every non-clock, non-reset signal of sram_to_fifo into one bundle.
// The master modport is the sram_to_fifo side. The slave modport is the
// environment side (requester, SRAM and FIFO).
//
// Signals:
//   start         transfer request, sampled only while the engine is idle
//   base_addr     first SRAM word address, latched when start is accepted
//   length        number of words to move (0 .. 2^aw), latched when start is accepted
//   sram_rd       one-cycle SRAM read strobe
//   sram_addr     SRAM read address, valid while sram_rd=1
//   sram_data_in  SRAM read data, valid while sram_done=1
//   sram_done     SRAM read-complete pulse
//   full          downstream FIFO cannot accept a word
//   push          FIFO write enable, one word per high cycle
//   fifo_data_out word written to the FIFO, valid while push=1
//   busy          engine is not idle
//   done          one-cycle pulse at the end of a transfer
interface sram_to_fifo_if #(
   parameter int dw = 32,
   parameter int aw = 10
);
   logic          start;
   logic [aw-1:0] base_addr;
   logic [aw:0]   length;
   logic          sram_rd;
   logic [aw-1:0] sram_addr;
   logic [dw-1:0] sram_data_in;
   logic          sram_done;
   logic          full;
   logic          push;
   logic [dw-1:0] fifo_data_out;
   logic          busy;
   logic          done;

   modport master (
      input  start, base_addr, length, sram_data_in, sram_done, full,
      output sram_rd, sram_addr, push, fifo_data_out, busy, done
   );

   modport slave (
      output start, base_addr, length, sram_data_in, sram_done, full,
      input  sram_rd, sram_addr, push, fifo_data_out, busy, done
   );
endinterface

// File: rtl/sram_to_fifo.sv
// rtl/sram_to_fifo.sv - moves a block of SRAM words into a downstream FIFO
//
// Purpose: on an accepted start, reads `length` consecutive SRAM words
// beginning at base_addr. The address wraps modulo 2^aw. Each word is pushed
// into a FIFO in ascending address order. Only one SRAM read is outstanding
// at any time. The engine stalls while the FIFO is full and pulses done at
// the end of the transfer.
//
// Ports:
//   wb_clk  single clock; all state changes on its rising edge
//   wb_rst  synchronous active-high reset; it has priority over start
//   bus     sram_to_fifo_if.master bundle (handshake, SRAM and FIFO signals)
module sram_to_fifo #(
   parameter int dw = 32,
   parameter int aw = 10
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   sram_to_fifo_if.master       bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_WAIT = 3'd2,
      ST_PUSH = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t        state_q,     state_d;
   logic [aw-1:0] addr_q,      addr_d;       // address of the word in flight
   logic [aw:0]   remaining_q, remaining_d;  // words still to push, 0 .. 2^aw
   logic [dw-1:0] data_q,      data_d;       // captured SRAM word
   logic [aw-1:0] sram_addr_q, sram_addr_d;  // held between reads

   // State register and datapath registers.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         sram_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
         sram_addr_q <= sram_addr_d;
      end
   end

   // Next-state and datapath update.
   // sram_addr is loaded only on the edge that enters READ. It equals addr
   // throughout the read strobe and keeps that value until the next read,
   // even though addr advances in PUSH.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      sram_addr_d = sram_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               addr_d      = bus.base_addr;
               remaining_d = bus.length;
               if (bus.length == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_READ;
                  sram_addr_d = bus.base_addr;
               end
            end
         end

         ST_READ: begin
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (bus.sram_done) begin
               data_d  = bus.sram_data_in;
               state_d = ST_PUSH;
            end
         end

         ST_PUSH: begin
            // While full is asserted, stall with every register frozen.
            if (!bus.full) begin
               addr_d      = addr_q + 1'b1;      // natural wrap at 2^aw
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == {{aw{1'b0}}, 1'b1}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_READ;
                  sram_addr_d = addr_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the current state. push also depends
   // combinationally on full, so a word leaves on the first non-full cycle.
   assign bus.sram_rd       = (state_q == ST_READ);
   assign bus.sram_addr     = sram_addr_q;
   assign bus.push          = (state_q == ST_PUSH) && !bus.full;
   assign bus.fifo_data_out = data_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_to_fifo.sv
// tb/tb_sram_to_fifo.sv - scoreboard bench for sram_to_fifo
module tb_sram_to_fifo;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;

   logic wb_clk = 1'b0;
   logic wb_rst;

   always #5 wb_clk = ~wb_clk;

   sram_to_fifo_if #(.dw(DW), .aw(AW)) bus ();

   sram_to_fifo #(.dw(DW), .aw(AW)) dut (
      .wb_clk (wb_clk),
      .wb_rst (wb_rst),
      .bus    (bus)
   );

   logic [DW-1:0] mem [0:DEPTH-1];

   int n_pass  = 0;
   int n_total = 0;

   logic [AW-1:0] exp_addr_q [$];
   logic [DW-1:0] exp_data_q [$];
   int exp_done  = 0;
   int done_seen = 0;

   int full_mode     = 2;   // 0 random, 1 forced full, 2 never full
   int resp_delay    = 0;   // 0 random 1..3, else fixed
   bit stray_done_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   // FIFO full driver
   always begin
      case (full_mode)
         0:       bus.full = ($urandom_range(0, 9) < 3);
         1:       bus.full = 1'b1;
         default: bus.full = 1'b0;
      endcase
      @(posedge wb_clk);
      #1;
   end

   // SRAM responder: answers each read strobe after 1..3 cycles, and
   // optionally throws a junk sram_done pulse into the READ cycle itself.
   initial begin
      logic [AW-1:0] a;
      int d;
      bus.sram_done    = 1'b0;
      bus.sram_data_in = '0;
      forever begin
         @(negedge wb_clk);
         if (bus.sram_rd === 1'b1) begin
            a = bus.sram_addr;
            d = (resp_delay > 0) ? resp_delay : $urandom_range(1, 3);
            if (stray_done_en && ($urandom_range(0, 1) == 1)) begin
               bus.sram_done    = 1'b1;
               bus.sram_data_in = 32'hDEAD_0000 ^ DW'(a);
            end
            @(posedge wb_clk);
            #1;
            bus.sram_done = 1'b0;
            for (int k = 1; k < d; k++) begin
               @(posedge wb_clk);
               #1;
            end
            bus.sram_done    = 1'b1;
            bus.sram_data_in = mem[a];
            @(posedge wb_clk);
            #1;
            bus.sram_done    = 1'b0;
            bus.sram_data_in = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT shows a read, push or done.
   always @(negedge wb_clk) begin
      if (wb_rst === 1'b0) begin
         if (bus.sram_rd === 1'b1) begin
            if (exp_addr_q.size() == 0) chk("unexpected_sram_rd", bus.sram_rd, 0);
            else chk("sram_addr", bus.sram_addr, exp_addr_q.pop_front());
         end
         if (bus.push === 1'b1) begin
            if (exp_data_q.size() == 0) chk("unexpected_push", bus.push, 0);
            else chk("push_data", bus.fifo_data_out, exp_data_q.pop_front());
         end
         if (bus.done === 1'b1) begin
            done_seen++;
            if (exp_done == 0) chk("unexpected_done", bus.done, 0);
            else begin
               chk("done_after_all_pushes", exp_data_q.size(), 0);
               exp_done--;
            end
         end
      end
   end

   // Reference model: a transfer reads base, base+1, ... modulo the SRAM size
   // and pushes exactly those words, then finishes with one done pulse.
   task automatic model_xfer(input logic [AW-1:0] base, input int len);
      logic [AW-1:0] a;
      for (int i = 0; i < len; i++) begin
         a = AW'((int'(base) + i) % DEPTH);
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem[a]);
      end
      exp_done++;
   endtask

   task automatic wait_done(input int target, input int budget, input bit stray_start);
      for (int c = 0; c < budget && !(done_seen >= target && bus.busy === 1'b0); c++) begin
         if (stray_start && bus.busy === 1'b1 && $urandom_range(0, 3) == 0) begin
            bus.start     = 1'b1;
            bus.base_addr = $urandom;
            bus.length    = (AW+1)'($urandom_range(1, 8));
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      bus.start = 1'b0;
      chk("xfer_complete", (done_seen >= target) && (bus.busy === 1'b0), 1);
   endtask

   task automatic run_xfer(input logic [AW-1:0] base, input int len, input bit stray_start,
                           input int budget);
      int target;
      target        = done_seen + 1;
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.length    = (AW+1)'(len);
      model_xfer(base, len);
      tick();
      bus.start = 1'b0;
      wait_done(target, budget, stray_start);
   endtask

   initial begin
      int target;
      bit found;
      logic [AW-1:0] b;
      int len;

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

      // Reset with start held high
      wb_rst        = 1'b1;
      bus.start     = 1'b1;
      bus.base_addr = 10'h155;
      bus.length    = 11'd5;
      tick();
      tick();
      @(negedge wb_clk);
      chk("rst_sram_rd", bus.sram_rd, 0);
      chk("rst_push", bus.push, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sram_addr", bus.sram_addr, 0);
      chk("rst_fifo_data", bus.fifo_data_out, 0);
      tick();
      bus.start = 1'b0;
      wb_rst    = 1'b0;
      @(negedge wb_clk);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_sram_rd", bus.sram_rd, 0);
      tick();

      // Basic three-word transfer
      mem[10'h010] = 32'hA0;
      mem[10'h011] = 32'hA1;
      mem[10'h012] = 32'hA2;
      resp_delay = 2;
      full_mode  = 2;
      run_xfer(10'h010, 3, 1'b0, 100);

      // Zero length
      bus.start     = 1'b1;
      bus.base_addr = 10'h005;
      bus.length    = '0;
      exp_done++;
      tick();
      bus.start = 1'b0;
      @(negedge wb_clk);
      chk("zero_len_done", bus.done, 1);
      chk("zero_len_busy", bus.busy, 1);
      @(negedge wb_clk);
      chk("zero_len_done_gone", bus.done, 0);
      chk("zero_len_idle", bus.busy, 0);
      tick();

      // Backpressure: full held for 5 cycles on entry to PUSH
      full_mode  = 1;
      resp_delay = 1;
      target        = done_seen + 1;
      bus.start     = 1'b1;
      bus.base_addr = 10'h100;
      bus.length    = 11'd2;
      model_xfer(10'h100, 2);
      tick();
      bus.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge wb_clk);
         if (bus.sram_done === 1'b1) found = 1'b1;
      end
      chk("bp_sram_done_seen", found, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge wb_clk);
         chk("bp_push_low", bus.push, 0);
         chk("bp_data_stable", bus.fifo_data_out, mem[10'h100]);
         chk("bp_no_sram_rd", bus.sram_rd, 0);
      end
      full_mode = 2;
      @(negedge wb_clk);
      chk("bp_push_released", bus.push, 1);
      wait_done(target, 100, 1'b0);

      // Wrap with stray start and sram_done pulses
      resp_delay    = 0;
      full_mode     = 0;
      stray_done_en = 1'b1;
      run_xfer(10'h3FF, 2, 1'b1, 200);

      // Reset while waiting for SRAM data; data arrives the following cycle
      stray_done_en = 1'b0;
      resp_delay    = 2;
      full_mode     = 2;
      bus.start     = 1'b1;
      bus.base_addr = 10'h200;
      bus.length    = 11'd3;
      model_xfer(10'h200, 3);
      tick();
      bus.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge wb_clk);
         if (bus.sram_rd === 1'b1) found = 1'b1;
      end
      chk("mid_rst_read_seen", found, 1);
      tick();
      wb_rst = 1'b1;
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_done = 0;
      tick();
      wb_rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge wb_clk);
         chk("mid_rst_push", bus.push, 0);
         chk("mid_rst_done", bus.done, 0);
         chk("mid_rst_busy", bus.busy, 0);
         chk("mid_rst_sram_rd", bus.sram_rd, 0);
      end
      tick();
      resp_delay = 0;
      run_xfer(10'h2F0, 4, 1'b0, 200);

      // Randomized transfers with stray inputs and random backpressure
      full_mode     = 0;
      stray_done_en = 1'b1;
      for (int t = 0; t < 25; t++) begin
         b = $urandom;
         if (t % 6 == 0) b = AW'(DEPTH - $urandom_range(1, 3));
         len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
         run_xfer(b, len, 1'b1, 40 * len + 40);
      end

      // Maximum length: every address once, with wrap
      full_mode     = 2;
      stray_done_en = 1'b0;
      resp_delay    = 1;
      b = $urandom;
      run_xfer(b, DEPTH, 1'b0, 8 * DEPTH);

      chk("end_addr_queue_empty", exp_addr_q.size(), 0);
      chk("end_data_queue_empty", exp_data_q.size(), 0);
      chk("end_done_outstanding", exp_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
